// File: rtl/sdram_chip_responder.sv
// Behavioural SDRAM chip model for the C64 core's 16-bit SDRAM bus: it decodes commands,
// tracks bank, mode and refresh state, keeps a small word store and flags protocol errors.
module sdram_chip_responder #(
    parameter int MEM_AW = 12,
    parameter int TRCD   = 1,
    parameter int TRFC   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_ba,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [15:0] sd_din,
    output logic [15:0] sd_dout,
    output logic        sd_doe,
    output logic        init_done,
    output logic [1:0]  cas_lat,
    output logic [15:0] refresh_cnt,
    output logic [7:0]  err
);

    localparam logic [2:0] CMD_NOP     = 3'b111;
    localparam logic [2:0] CMD_ACTIVE  = 3'b011;
    localparam logic [2:0] CMD_READ    = 3'b101;
    localparam logic [2:0] CMD_WRITE   = 3'b100;
    localparam logic [2:0] CMD_BST     = 3'b110;
    localparam logic [2:0] CMD_PRE     = 3'b010;
    localparam logic [2:0] CMD_REFRESH = 3'b001;
    localparam logic [2:0] CMD_LMR     = 3'b000;

    localparam logic [1:0] ST_WAIT_PRE  = 2'd0;
    localparam logic [1:0] ST_WAIT_MODE = 2'd1;
    localparam logic [1:0] ST_READY     = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        init_q, init_d;
    logic [1:0]  cl_q, cl_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  trfc_q, trfc_d;
    logic [3:0]  act_q, act_d;
    logic [12:0] row_q [4];
    logic [12:0] row_d [4];
    logic [2:0]  cnt_q [4];
    logic [2:0]  cnt_d [4];
    // Read pipeline: stage 0 is the output register, CL=2 enters stage 1, CL=3 enters stage 2.
    logic        p1_v_q, p1_v_d, p2_v_q, p2_v_d;
    logic [15:0] p1_data_q, p1_data_d, p2_data_q, p2_data_d;
    logic        doe_q, doe_d;
    logic [15:0] dout_q, dout_d;

    logic [15:0] mem_q [2**MEM_AW];

    logic [2:0]        cmd_s;
    logic              gated_s;
    logic              early_s;
    logic              wr_en_s;
    logic [23:0]       full_addr_s;
    logic [MEM_AW-1:0] idx_s;
    logic [15:0]       rd_data_s;

    assign cmd_s       = sd_cs ? CMD_NOP : {sd_ras, sd_cas, sd_we};
    assign gated_s     = !init_q;
    assign full_addr_s = {sd_ba, row_q[sd_ba], sd_addr[8:0]};
    assign idx_s       = full_addr_s[MEM_AW-1:0];
    assign rd_data_s   = mem_q[idx_s];
    assign early_s     = ({29'd0, cnt_q[sd_ba]} + 32'd1) < TRCD;
    assign wr_en_s     = (cmd_s == CMD_WRITE) && init_q && !reset;

    // Next-state decode of the command currently on the pins.
    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        cl_d      = cl_q;
        rcnt_d    = rcnt_q;
        err_d     = err_q;
        act_d     = act_q;
        row_d     = row_q;
        trfc_d    = (trfc_q != 8'd0) ? (trfc_q - 8'd1) : 8'd0;
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = (cnt_q[b] == 3'd7) ? 3'd7 : (cnt_q[b] + 3'd1);
        end
        p2_v_d    = 1'b0;
        p2_data_d = 16'd0;
        p1_v_d    = p2_v_q;
        p1_data_d = p2_data_q;
        doe_d     = p1_v_q;
        dout_d    = p1_v_q ? p1_data_q : dout_q;

        if ((cmd_s != CMD_NOP) && (trfc_q != 8'd0)) begin
            err_d[6] = 1'b1;
        end else begin
            err_d[6] = err_q[6];
        end

        case (cmd_s)
            CMD_ACTIVE: begin
                if (gated_s) begin
                    err_d[0] = 1'b1;
                end else begin
                    err_d[1]       = err_q[1] | act_q[sd_ba];
                    act_d[sd_ba]   = 1'b1;
                    row_d[sd_ba]   = sd_addr;
                    cnt_d[sd_ba]   = 3'd0;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (gated_s) begin
                    err_d[0] = 1'b1;
                end else begin
                    err_d[2] = err_q[2] | !act_q[sd_ba];
                    err_d[3] = err_q[3] | early_s;
                    act_d[sd_ba] = sd_addr[10] ? 1'b0 : act_q[sd_ba];
                    if (cmd_s == CMD_WRITE) begin
                        err_d[7] = err_q[7] | p1_v_q | p2_v_q;
                    end else if (cl_q == 2'd3) begin
                        p2_v_d    = 1'b1;
                        p2_data_d = rd_data_s;
                    end else begin
                        p1_v_d    = 1'b1;
                        p1_data_d = rd_data_s;
                    end
                end
            end
            CMD_PRE: begin
                if (sd_addr[10]) begin
                    act_d   = 4'b0000;
                    state_d = (state_q == ST_WAIT_PRE) ? ST_WAIT_MODE : state_q;
                end else begin
                    act_d[sd_ba] = 1'b0;
                end
            end
            CMD_REFRESH: begin
                if (gated_s) begin
                    err_d[0] = 1'b1;
                end else begin
                    rcnt_d   = rcnt_q + 16'd1;
                    trfc_d   = 8'(TRFC);
                    err_d[4] = err_q[4] | (|act_q);
                end
            end
            CMD_LMR: begin
                if (state_q != ST_WAIT_PRE) begin
                    if (((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) && (sd_addr[2:0] == 3'b000)) begin
                        cl_d = sd_addr[5:4];
                    end else begin
                        err_d[5] = 1'b1;
                    end
                    state_d = ST_READY;
                    init_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            CMD_BST, CMD_NOP: begin
                state_d = state_q;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Control state, read pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT_PRE;
            init_q    <= 1'b0;
            cl_q      <= 2'd2;
            rcnt_q    <= 16'd0;
            err_q     <= 8'd0;
            trfc_q    <= 8'd0;
            act_q     <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                row_q[b] <= 13'd0;
                cnt_q[b] <= 3'd0;
            end
            p1_v_q    <= 1'b0;
            p1_data_q <= 16'd0;
            p2_v_q    <= 1'b0;
            p2_data_q <= 16'd0;
            doe_q     <= 1'b0;
            dout_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            cl_q      <= cl_d;
            rcnt_q    <= rcnt_d;
            err_q     <= err_d;
            trfc_q    <= trfc_d;
            act_q     <= act_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            p1_v_q    <= p1_v_d;
            p1_data_q <= p1_data_d;
            p2_v_q    <= p2_v_d;
            p2_data_q <= p2_data_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
        end
    end

    // Backing store survives reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[idx_s] <= sd_din;
        end
    end

    assign sd_dout     = dout_q;
    assign sd_doe      = doe_q;
    assign init_done   = init_q;
    assign cas_lat     = cl_q;
    assign refresh_cnt = rcnt_q;
    assign err         = err_q;

endmodule

// File: doc/sdram_chip_responder.md
Name: sdram_chip_responder

Overview:
- Synthesizable responder for the other end of the 16-bit single-chip SDRAM bus that the C64 core's SDRAM controller drives. It decodes the command pins and tracks per-bank row state, mode register and refresh.
- It stores 16-bit words in a small on-chip array and returns read data exactly CAS-latency cycles after READ.
- Used in simulation benches and in FPGA loop-back builds.
- Flags protocol violations in sticky error bits.

Parameters:
- MEM_AW, 12: backing-store word address width (2^MEM_AW x 16 bits).
- TRCD, 1: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- TRFC, 4: cycles after AUTO_REFRESH during which only NOP/deselect is legal.

Ports:
- clk  in  1  bus clock; all pins sampled on rising edge.
- reset  in  1  synchronous, active-high.
- sd_addr  in  13  multiplexed row/column/mode address.
- sd_ba  in  2  bank select.
- sd_cs  in  1  chip select, active low.
- sd_ras  in  1  RAS, active low.
- sd_cas  in  1  CAS, active low.
- sd_we  in  1  WE, active low.
- sd_din  in  16  write data from the controller.
- sd_dout  out  16  read data.
- sd_doe  out  1  read data valid / output enable.
- init_done  out  1  precharge-all and LOAD_MODE both completed.
- cas_lat  out  2  latched CAS latency.
- refresh_cnt  out  16  count of accepted AUTO_REFRESH commands; wraps 0xFFFF->0.
- err  out  8  sticky protocol-error flags.

Behaviour:
- Reset values:
  - sd_dout=0, sd_doe=0, init_done=0, cas_lat=2, refresh_cnt=0, err=0.
  - All banks idle; read pipeline cleared.
  - Memory contents are not cleared.
- Command decode: cmd = {ras,cas,we}, decoded only when cs=0; cs=1 means NOP.
  - 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST_TERMINATE (ignored), 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE.
- Init FSM (states WAIT_PRE -> WAIT_MODE -> READY):
  - PRECHARGE with A10=1 moves WAIT_PRE->WAIT_MODE.
  - LOAD_MODE in WAIT_MODE moves to READY and sets init_done=1 on the next cycle.
  - LOAD_MODE in READY is also accepted and re-latches the mode.
- LOAD_MODE:
  - cas_lat <= addr[6:4] when that field is 2 or 3.
  - Any other CL value, or addr[2:0]!=000, sets err[5] and keeps the previous cas_lat.
- Per-bank state (4 banks): active flag, 13-bit open row, 3-bit cycles-since-ACTIVE counter that saturates at 7.
  - ACTIVE: sets active, row <= addr, counter <= 0.
  - ACTIVE on an already-active bank sets err[1] and overwrites the row.
- PRECHARGE: A10=1 idles all banks; A10=0 idles bank sd_ba. Precharging an idle bank is legal.
- READ/WRITE:
  - column = addr[8:0].
  - Word index = {ba, row, column}[MEM_AW-1:0].
  - Target bank idle sets err[2] and the access is still performed using the stale row.
  - Counter < TRCD-1 (i.e. fewer than TRCD cycles since ACTIVE) sets err[3] and the access is performed anyway.
  - A10=1 (auto-precharge) idles the bank the cycle after the command.
  - WRITE stores sd_din sampled in the command cycle.
- Read latency:
  - READ at edge N sets sd_doe=1 and sd_dout=mem[idx] during the cycle after edge N+cas_lat-1, i.e. visible to the controller at edge N+cas_lat.
  - sd_doe is high for exactly 1 cycle (burst length 1).
  - Implementation: 3-deep shift pipeline tagged with the CL in effect at issue time.
  - Back-to-back READs produce back-to-back valid cycles.
  - sd_dout holds its last value while sd_doe=0.
- Read-after-write: a READ issued on the cycle after a WRITE to the same index returns the new data.
- WRITE while a read result is still in the pipeline sets err[7] (bus turnaround conflict); both operations still complete.
- AUTO_REFRESH:
  - Increments refresh_cnt.
  - Starts the TRFC down-counter.
  - Any bank active at that moment sets err[4].
- Any command other than NOP/deselect while the TRFC counter is non-zero sets err[6] and is otherwise still executed.
- ACTIVE/READ/WRITE/AUTO_REFRESH while init_done=0 sets err[0] and is ignored; no state or memory change.
- Simultaneous events: a command is processed in the same edge as pipeline output advance; the pipeline output takes priority on sd_dout.
- Reset mid-operation: pipeline flushed, so sd_doe=0 from the cycle after reset is sampled. Any pending data is lost.

Test Plan:
- PRECHARGE(A10=1), then LOAD_MODE addr=0x220 -> init_done=1 next cycle, cas_lat=2, err=0.
- After init: ACTIVE ba=1 row=0x0055; 1 cycle later WRITE col=0x0AB A10=1 din=0xBEEF; ACTIVE; READ same address -> sd_doe=1 for 1 cycle, sd_dout=0xBEEF, exactly 2 edges after READ, err=0.
- LOAD_MODE addr=0x230, then repeat the read -> data valid 3 edges after READ; LOAD_MODE addr=0x250 -> err[5]=1, cas_lat stays 3.
- 3 AUTO_REFRESH spaced 8 cycles apart -> refresh_cnt=3, err=0. Then AUTO_REFRESH and ACTIVE 2 cycles later -> err[6]=1. AUTO_REFRESH with bank 0 active -> err[4]=1.
- Without init: ACTIVE -> err[0]=1, no bank state change. After init: ACTIVE twice on bank 2 -> err[1]=1. READ on idle bank 3 -> err[2]=1. With TRCD=2, READ 1 cycle after ACTIVE -> err[3]=1.
- Issue READ (CL=3), assert reset 1 cycle later -> sd_doe never asserts, all outputs return to reset values. Previously written memory is still readable after re-init.
